avl_img_slave: RTL and testbench
================================

// Module: avl_img_slave
// PURPOSE
//   Avalon-MM slave at the far end of the JTAG-to-Avalon master conduit (AVL_MM_slave_0).
//   Holds a 256x256 8-bit pixel buffer plus a small register file.
//   Contains an in-place pixel engine (invert or threshold) started by the host over JTAG.
//   First compute stage of the CV accelerator.
// PARAMETERS
//   ADDR_W    17     Avalon byte-address width; addr[16]=0 selects pixel RAM, addr[16]=1 selects registers
//   DATA_W    8      Avalon data width, equal to pixel width
//   MEM_AW    16     pixel RAM address width; depth is 2**MEM_AW
//   ID_VALUE  8'hC5  constant returned by the ID register
// PORTS
//   clk_clk             in   1       single clock
//   reset_reset_n       in   1       asynchronous, active-low reset
//   avs_s0_address      in   17      byte address
//   avs_s0_read         in   1       read request
//   avs_s0_readdata     out  8       read data; valid in the cycle waitrequest is low with read high
//   avs_s0_write        in   1       write request
//   avs_s0_writedata    in   8       write data
//   avs_s0_waitrequest  out  1       stall; the master holds address, data and command while it is high
// BEHAVIOUR
//   Reset values: readdata=0, rd_ack=0, CTRL=0, THRESH=8'h80, busy=0, done=0, engine IDLE.
//   RAM contents are not reset.
//   Register map (addr[16]=1, addr[1:0]); other register addresses read 0 and ignore writes.
//     0 CTRL    W: bit0 start (self-clearing, reads 0); RW: bit1 op (0=invert, 1=threshold)
//     1 THRESH  RW 8-bit threshold
//     2 STATUS  R: bit0 busy, bit1 done (sticky); writing 1 to bit1 clears done
//     3 ID      R: ID_VALUE
//   Reads take 2 cycles for RAM and registers alike.
//     Cycle 1: waitrequest=1; RAM/register addressed; rd_ack<=1.
//     Cycle 2: waitrequest=0; readdata registered; rd_ack<=0.
//   Writes take 1 cycle (waitrequest=0) unless stalled.
//   Busy stall: any RAM access (addr[16]=0) while busy holds waitrequest=1 until busy falls.
//     Register accesses never stall on busy.
//   waitrequest = (read & ~rd_ack) | (~addr[16] & (read|write) & busy). It is combinational.
//   read & write both high is illegal; the write is executed and the read is ignored (waitrequest=0).
//   Engine FSM (single-port RAM shared with Avalon; the engine owns the port while busy):
//     IDLE -> RD on a start write when busy=0; set busy, clear done, ptr=0.
//     RD: RAM read at ptr -> WR.
//     WR: write f(q) at ptr.
//       If ptr = 2**MEM_AW-1 -> DONE, else ptr++ -> RD.
//     DONE: busy=0, done=1 -> IDLE.
//     Total 2*2**MEM_AW + 1 cycles from the start write to busy=0.
//   f(q): op=0 -> ~q; op=1 -> (q >= THRESH) ? 8'hFF : 8'h00.
//     op and THRESH are sampled at start.
//   Start while busy: ignored; op and THRESH writes still update the registers but not the running pass.
//   ptr has MEM_AW bits and the terminal compare is explicit; no wrap past the last pixel.
//   Async reset mid-pass: FSM returns to IDLE, busy=0, done=0; RAM is left partially processed.
// STRUCTURE
//   Package avl_img_pkg:
//     register offsets REG_CTRL/REG_THRESH/REG_STATUS/REG_ID
//     OP_INVERT/OP_THRESH
//     typedef enum {IDLE, RD, WR, DONE} eng_state_t
//   Sub-module avl_img_ram: single-port synchronous RAM (addr, we, wdata, q), 1-cycle read, M10K-inferable.
//   Top level: Avalon decode, rd_ack flop, register file, engine FSM, RAM port mux (engine when busy).
// TESTING
//   1. After reset, read 0x10003 -> waitrequest high 1 cycle, readdata 8'hC5; read 0x10001 -> 8'h80.
//   2. Write 0x00123=8'h5A, then read 0x00123 -> 8'h5A after 1 wait cycle.
//      Write 0x0FFFF=8'h01, read back -> 8'h01.
//   3. Preload pix[0]=8'h00, pix[0xFFFF]=8'hF0; write CTRL=8'h01 (invert).
//      Poll STATUS: busy=1 until cycle 131073, then 8'h02.
//      Then pix[0]=8'hFF, pix[0xFFFF]=8'h0F.
//   4. THRESH=8'h40; pix[5]=8'h40, pix[6]=8'h3F; CTRL=8'h03 -> pix[5]=8'hFF, pix[6]=8'h00.
//      Write STATUS=8'h02 -> STATUS reads 8'h00.
//   5. RAM read issued mid-pass -> waitrequest held high until busy=0, then post-pass data returned.
//      Second start mid-pass -> ignored; pass length unchanged.
//   6. Assert reset_reset_n=0 mid-pass -> STATUS=0 and THRESH=8'h80 after release.
//      A new start then completes normally.

Source files
------------

// File: rtl/avl_img_pkg.sv
// Shared register offsets, engine opcodes and engine state type for the
// Avalon image slave.
package avl_img_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_THRESH = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_ID     = 2'd3;

    localparam logic OP_INVERT = 1'b0;
    localparam logic OP_THRESH = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } eng_state_t;

endpackage

// File: rtl/avl_img_ram.sv
// Single-port synchronous pixel RAM, one-cycle registered read.
// No reset on storage or output so it maps onto block RAM.
module avl_img_ram #(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/avl_img_slave.sv
// Avalon-MM slave holding a pixel buffer, a small register file and an
// in-place invert/threshold engine that borrows the RAM port while busy.
//
//   state | meaning
//   IDLE  | waiting for a start write; Avalon owns the RAM
//   RD    | engine reads the pixel at ptr
//   WR    | engine writes f(q) back at ptr, advances or finishes
//   DONE  | pass finished, done flag set, RAM returned to Avalon
module avl_img_slave
    import avl_img_pkg::*;
#(
    parameter int                ADDR_W   = 17,
    parameter int                DATA_W   = 8,
    parameter int                MEM_AW   = 16,
    parameter logic [DATA_W-1:0] ID_VALUE = 8'hC5
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [ADDR_W-1:0] avs_s0_address,
    input  logic              avs_s0_read,
    output logic [DATA_W-1:0] avs_s0_readdata,
    input  logic              avs_s0_write,
    input  logic [DATA_W-1:0] avs_s0_writedata,
    output logic              avs_s0_waitrequest
);

    localparam logic [MEM_AW-1:0] PTR_LAST = '1;

    eng_state_t        state_q, state_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic              busy;
    logic              eng_we;
    logic              done_set;
    logic [DATA_W-1:0] eng_wdata;

    logic              reg_sel;
    logic [1:0]        reg_off;
    logic              ram_stall;
    logic              rd_fire;
    logic              wr_fire;
    logic              reg_wr;
    logic              start;

    logic              rd_ack_q;
    logic              rd_src_ram_q;
    logic [DATA_W-1:0] rd_reg_q;
    logic [DATA_W-1:0] reg_rdata;

    logic              op_q;
    logic [DATA_W-1:0] thresh_q;
    logic              done_q;
    logic              run_op_q;
    logic [DATA_W-1:0] run_thr_q;

    logic [MEM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    assign reg_sel = avs_s0_address[ADDR_W-1];
    assign reg_off = avs_s0_address[1:0];
    assign busy    = (state_q == RD) || (state_q == WR);

    // read+write together is treated as a plain write
    assign ram_stall          = ~reg_sel & (avs_s0_read | avs_s0_write) & busy;
    assign avs_s0_waitrequest = (avs_s0_read & ~avs_s0_write & ~rd_ack_q) | ram_stall;
    assign rd_fire            = avs_s0_read & ~avs_s0_write & ~rd_ack_q & ~ram_stall;
    assign wr_fire            = avs_s0_write & ~ram_stall;
    assign reg_wr             = wr_fire & reg_sel;
    assign start              = reg_wr & (reg_off == REG_CTRL) & avs_s0_writedata[0] & ~busy;

    always_comb begin
        reg_rdata = '0;
        case (reg_off)
            REG_CTRL:   reg_rdata[1] = op_q;
            REG_THRESH: reg_rdata    = thresh_q;
            REG_STATUS: begin
                reg_rdata[0] = busy;
                reg_rdata[1] = done_q;
            end
            default:    reg_rdata    = ID_VALUE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_ack_q     <= 1'b0;
            rd_src_ram_q <= 1'b0;
            rd_reg_q     <= '0;
        end else begin
            rd_ack_q <= rd_fire;
            if (rd_fire) begin
                rd_src_ram_q <= ~reg_sel;
                rd_reg_q     <= reg_rdata;
            end
        end
    end

    assign avs_s0_readdata = rd_src_ram_q ? ram_q : rd_reg_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            op_q      <= OP_INVERT;
            thresh_q  <= 8'h80;
            done_q    <= 1'b0;
            run_op_q  <= OP_INVERT;
            run_thr_q <= 8'h80;
        end else begin
            if (reg_wr && reg_off == REG_CTRL) begin
                op_q <= avs_s0_writedata[1];
            end
            if (reg_wr && reg_off == REG_THRESH) begin
                thresh_q <= avs_s0_writedata;
            end
            if (start) begin
                run_op_q  <= avs_s0_writedata[1];
                run_thr_q <= thresh_q;
                done_q    <= 1'b0;
            end else if (done_set) begin
                done_q <= 1'b1;
            end else if (reg_wr && reg_off == REG_STATUS && avs_s0_writedata[1]) begin
                done_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        eng_we   = 1'b0;
        done_set = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RD;
                    ptr_d   = '0;
                end
            end
            RD: state_d = WR;
            WR: begin
                eng_we = 1'b1;
                // explicit terminal compare: ptr never wraps past the last pixel
                if (ptr_q == PTR_LAST) begin
                    state_d  = DONE;
                    done_set = 1'b1;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign eng_wdata = (run_op_q == OP_THRESH) ? ((ram_q >= run_thr_q) ? '1 : '0) : ~ram_q;

    assign ram_addr  = busy ? ptr_q  : avs_s0_address[MEM_AW-1:0];
    assign ram_we    = busy ? eng_we : (wr_fire & ~reg_sel);
    assign ram_wdata = busy ? eng_wdata : avs_s0_writedata;

    avl_img_ram #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk   (clk_clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_avl_img_slave.sv
// Directed bench for avl_img_slave with a reduced pixel buffer (256 pixels)
// and a whole-buffer behavioural model checked every cycle.
module tb_avl_img_slave;

    localparam int MEM_AW = 8;
    localparam int NPIX   = 2**MEM_AW;
    localparam int TMO    = 4000;

    logic        clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [16:0] avs_s0_address = '0;
    logic        avs_s0_read = 1'b0;
    logic [7:0]  avs_s0_readdata;
    logic        avs_s0_write = 1'b0;
    logic [7:0]  avs_s0_writedata = '0;
    logic        avs_s0_waitrequest;

    int checks = 0;
    int failures = 0;

    avl_img_slave #(
        .ADDR_W   (17),
        .DATA_W   (8),
        .MEM_AW   (MEM_AW),
        .ID_VALUE (8'hC5)
    ) dut (
        .clk_clk            (clk),
        .reset_reset_n      (reset_reset_n),
        .avs_s0_address     (avs_s0_address),
        .avs_s0_read        (avs_s0_read),
        .avs_s0_readdata    (avs_s0_readdata),
        .avs_s0_write       (avs_s0_write),
        .avs_s0_writedata   (avs_s0_writedata),
        .avs_s0_waitrequest (avs_s0_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fpix(input logic op, input logic [7:0] t, input logic [7:0] q);
        if (op) return (q >= t) ? 8'hFF : 8'h00;
        return ~q;
    endfunction

    // Model: pixel array, registers, and the pass as a 2*NPIX-cycle busy window
    // whose effect is applied to the whole buffer when it closes.
    logic [7:0]  pix_m   [NPIX];
    bit          known_m [NPIX];
    logic        op_m = 1'b0;
    logic [7:0]  thr_m = 8'h80;
    logic        done_m = 1'b0;
    logic        op_run = 1'b0;
    logic [7:0]  thr_run = 8'h80;
    int unsigned busy_left = 0;
    int          rd_cnt = 0;
    logic [7:0]  exp_rd = '0;
    bit          exp_known = 1'b0;

    always @(posedge clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            if (busy_left > 0) begin
                for (int i = 0; i < NPIX; i++) known_m[i] <= 1'b0;
            end
            busy_left <= 0;
            done_m    <= 1'b0;
            op_m      <= 1'b0;
            thr_m     <= 8'h80;
            rd_cnt    <= 0;
        end else begin
            automatic bit         busy_pre = (busy_left > 0);
            automatic logic       a16  = avs_s0_address[16];
            automatic int         idx  = int'(avs_s0_address[MEM_AW-1:0]);
            automatic logic [1:0] off  = avs_s0_address[1:0];
            automatic bit         stall = !a16 && (avs_s0_read || avs_s0_write) && busy_pre;

            if (avs_s0_read && !avs_s0_write) begin
                if (!stall) begin
                    if (rd_cnt == 0) begin
                        rd_cnt <= 1;
                        if (!a16) begin
                            exp_rd    <= pix_m[idx];
                            exp_known <= known_m[idx];
                        end else begin
                            exp_known <= 1'b1;
                            case (off)
                                2'd0: exp_rd <= {6'b0, op_m, 1'b0};
                                2'd1: exp_rd <= thr_m;
                                2'd2: exp_rd <= {6'b0, done_m, busy_pre};
                                default: exp_rd <= 8'hC5;
                            endcase
                        end
                    end else begin
                        rd_cnt <= 0;
                    end
                end
            end else begin
                rd_cnt <= 0;
            end

            if (busy_pre) begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) begin
                    for (int i = 0; i < NPIX; i++) pix_m[i] <= fpix(op_run, thr_run, pix_m[i]);
                    done_m <= 1'b1;
                end
            end

            if (avs_s0_write && !stall) begin
                if (!a16) begin
                    pix_m[idx]   <= avs_s0_writedata;
                    known_m[idx] <= 1'b1;
                end else begin
                    case (off)
                        2'd0: begin
                            op_m <= avs_s0_writedata[1];
                            if (avs_s0_writedata[0] && !busy_pre) begin
                                busy_left <= 2 * NPIX;
                                op_run    <= avs_s0_writedata[1];
                                thr_run   <= thr_m;
                                done_m    <= 1'b0;
                            end
                        end
                        2'd1: thr_m <= avs_s0_writedata;
                        2'd2: if (avs_s0_writedata[1]) done_m <= 1'b0;
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_reset_n) begin
            automatic bit busy_m = (busy_left > 0);
            automatic bit stall  = !avs_s0_address[16] && (avs_s0_read || avs_s0_write) && busy_m;
            automatic bit ew     = (avs_s0_read && !avs_s0_write) ? (stall || rd_cnt == 0) : stall;
            chk("waitrequest", {31'b0, avs_s0_waitrequest}, {31'b0, ew});
            if (avs_s0_read && !avs_s0_write && !avs_s0_waitrequest && exp_known) begin
                chk("readdata", {24'b0, avs_s0_readdata}, {24'b0, exp_rd});
            end
        end
    end

    // Tasks are entered just after a rising edge and leave just after one.
    task automatic avl_write(input logic [16:0] a, input logic [7:0] d);
        bit ok = 1'b0;
        avs_s0_address   = a;
        avs_s0_writedata = d;
        avs_s0_write     = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (!avs_s0_waitrequest) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("write_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        avs_s0_write = 1'b0;
    endtask

    task automatic avl_read(input logic [16:0] a, output logic [7:0] d, output int waits);
        bit ok = 1'b0;
        waits = 0;
        avs_s0_address = a;
        avs_s0_read    = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (!avs_s0_waitrequest) begin
                ok = 1'b1;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        if (!ok) chk("read_timeout", 32'd0, 32'd1);
        d = avs_s0_readdata;
        @(posedge clk); #1;
        avs_s0_read = 1'b0;
    endtask

    task automatic rd_expect(input string name, input logic [16:0] a, input logic [7:0] exp);
        logic [7:0] d;
        int w;
        avl_read(a, d, w);
        chk(name, {24'b0, d}, {24'b0, exp});
    endtask

    task automatic wait_idle();
        logic [7:0] d;
        int w;
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            avl_read(17'h10002, d, w);
            if (!d[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("busy_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        int w;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_readdata", {24'b0, avs_s0_readdata}, 32'h0);
        chk("reset_waitrequest", {31'b0, avs_s0_waitrequest}, 32'h0);
        @(negedge clk);
        reset_reset_n = 1'b1;
        @(posedge clk); #1;

        // register reads after reset
        avl_read(17'h10003, d, w);
        chk("id_value", {24'b0, d}, 32'hC5);
        chk("id_waits", w, 1);
        rd_expect("thresh_reset", 17'h10001, 8'h80);
        rd_expect("ctrl_reset", 17'h10000, 8'h00);
        rd_expect("status_reset", 17'h10002, 8'h00);

        // RAM write / read-back
        avl_write(17'h00123, 8'h5A);
        avl_read(17'h00123, d, w);
        chk("ram_rd_123", {24'b0, d}, 32'h5A);
        chk("ram_rd_waits", w, 1);
        avl_write(17'h0FFFF, 8'h01);
        rd_expect("ram_rd_last", 17'h0FFFF, 8'h01);

        // invert pass; a RAM read right after start stalls for the whole pass
        avl_write(17'h00000, 8'h00);
        avl_write(17'h0FFFF, 8'hF0);
        avl_write(17'h10000, 8'h01);
        avl_read(17'h00000, d, w);
        chk("inv_pix0", {24'b0, d}, 32'hFF);
        chk("pass_stall_waits", w, 513);
        rd_expect("inv_pix_last", 17'h0FFFF, 8'h0F);
        rd_expect("inv_pix_123", 17'h00123, 8'hA5);
        rd_expect("status_done", 17'h10002, 8'h02);

        // threshold pass with boundary pixels
        avl_write(17'h10001, 8'h40);
        avl_write(17'h00005, 8'h40);
        avl_write(17'h00006, 8'h3F);
        avl_write(17'h10000, 8'h03);
        rd_expect("status_busy", 17'h10002, 8'h01);
        wait_idle();
        rd_expect("thr_pix5", 17'h00005, 8'hFF);
        rd_expect("thr_pix6", 17'h00006, 8'h00);
        rd_expect("status_done2", 17'h10002, 8'h02);
        avl_write(17'h10002, 8'h02);
        rd_expect("status_cleared", 17'h10002, 8'h00);
        rd_expect("ctrl_op", 17'h10000, 8'h02);

        // register updates and a second start while a pass is running
        avl_write(17'h10000, 8'h01);
        repeat (50) @(posedge clk);
        #1;
        avl_write(17'h10001, 8'h10);
        avl_write(17'h10000, 8'h03);
        rd_expect("midpass_status", 17'h10002, 8'h01);
        rd_expect("midpass_pix5", 17'h00005, 8'h00);
        rd_expect("midpass_pix6", 17'h00006, 8'hFF);
        rd_expect("midpass_thresh", 17'h10001, 8'h10);
        rd_expect("midpass_ctrl", 17'h10000, 8'h02);

        // async reset in the middle of a pass, then a clean pass
        avl_write(17'h10000, 8'h01);
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset_reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_reset_n = 1'b1;
        @(posedge clk); #1;
        rd_expect("rst_status", 17'h10002, 8'h00);
        rd_expect("rst_thresh", 17'h10001, 8'h80);
        rd_expect("rst_ctrl", 17'h10000, 8'h00);
        avl_write(17'h00007, 8'h33);
        avl_write(17'h10000, 8'h01);
        avl_read(17'h00007, d, w);
        chk("post_rst_pix7", {24'b0, d}, 32'hCC);
        chk("post_rst_waits", w, 513);
        rd_expect("post_rst_status", 17'h10002, 8'h02);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
